// File: rtl/mips_pkg.sv
// ============================================================================
// mips_pkg : opcode constants, instruction field slices and source-use decode
// Rev 1.0
// ============================================================================
`default_nettype none

package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 26;
  localparam int RS_MSB  = 25;
  localparam int RS_LSB  = 21;
  localparam int RT_MSB  = 20;
  localparam int RT_LSB  = 16;
  localparam int IMM_MSB = 15;

  function automatic logic uses_rs(input logic [5:0] op);
    return !((op == OP_J) || (op == OP_JAL) || (op == OP_LUI));
  endfunction

  function automatic logic uses_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
  endfunction

endpackage

`default_nettype wire

// File: rtl/operand_bypass.sv
// ============================================================================
// operand_bypass : resolves one source operand from MEM / WB / register file
// Rev 1.0
// ============================================================================
`default_nettype none

module operand_bypass
  import mips_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic [RADDR_W-1:0] addr,
  input  logic [XLEN-1:0]    rf_data,
  input  logic               mem_reg_write,
  input  logic               mem_mem_read,
  input  logic [RADDR_W-1:0] mem_dst,
  input  logic [XLEN-1:0]    mem_result,
  input  logic               wb_reg_write,
  input  logic [RADDR_W-1:0] wb_dst,
  input  logic [XLEN-1:0]    wb_data,
  output logic [XLEN-1:0]    value
);

  logic w_zero;
  logic w_mem_hit;
  logic w_wb_hit;

  // A load in MEM has no data yet; that case is stalled, not bypassed.
  assign w_zero    = (addr == '0);
  assign w_mem_hit = mem_reg_write && !mem_mem_read && (mem_dst == addr);
  assign w_wb_hit  = wb_reg_write && (wb_dst == addr);

  always_comb begin
    value = rf_data;
    if (w_zero)         value = '0;
    else if (w_mem_hit) value = mem_result;
    else if (w_wb_hit)  value = wb_data;
  end

endmodule

`default_nettype wire

// File: rtl/operand_fetch_stage.sv
// ============================================================================
// operand_fetch_stage : ID-stage operand read, bypass, RAW stall and ID/EX reg
// Rev 1.0
// ============================================================================
`default_nettype none

module operand_fetch_stage
  import mips_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_valid,
  input  logic [31:0]        if_instr,
  input  logic [XLEN-1:0]    if_pc,
  input  logic               flush,
  output logic [RADDR_W-1:0] rf_rs_addr,
  output logic [RADDR_W-1:0] rf_rt_addr,
  input  logic [XLEN-1:0]    rf_rs_data,
  input  logic [XLEN-1:0]    rf_rt_data,
  input  logic               ex_reg_write,
  input  logic [RADDR_W-1:0] ex_dst,
  input  logic               mem_reg_write,
  input  logic               mem_mem_read,
  input  logic [RADDR_W-1:0] mem_dst,
  input  logic [XLEN-1:0]    mem_result,
  input  logic               wb_reg_write,
  input  logic [RADDR_W-1:0] wb_dst,
  input  logic [XLEN-1:0]    wb_data,
  output logic               stall_out,
  output logic               id_valid,
  output logic [XLEN-1:0]    id_pc,
  output logic [31:0]        id_instr,
  output logic [XLEN-1:0]    id_rs_val,
  output logic [XLEN-1:0]    id_rt_val,
  output logic [XLEN-1:0]    id_imm,
  output logic [31:0]        stall_cycles
);

  logic [5:0]         w_op;
  logic [XLEN-1:0]    w_rs_val;
  logic [XLEN-1:0]    w_rt_val;
  logic               w_rs_used;
  logic               w_rt_used;
  logic               w_rs_hz;
  logic               w_rt_hz;
  logic               w_stall;

  logic               r_id_valid;
  logic [XLEN-1:0]    r_id_pc;
  logic [31:0]        r_id_instr;
  logic [XLEN-1:0]    r_id_rs_val;
  logic [XLEN-1:0]    r_id_rt_val;
  logic [XLEN-1:0]    r_id_imm;
  logic [31:0]        r_stall_cycles;

  assign w_op       = if_instr[OP_MSB:OP_LSB];
  assign rf_rs_addr = if_instr[RS_MSB:RS_LSB];
  assign rf_rt_addr = if_instr[RT_MSB:RT_LSB];

  operand_bypass #(.XLEN(XLEN), .RADDR_W(RADDR_W)) u_rs_bypass (
    .addr          (rf_rs_addr),
    .rf_data       (rf_rs_data),
    .mem_reg_write (mem_reg_write),
    .mem_mem_read  (mem_mem_read),
    .mem_dst       (mem_dst),
    .mem_result    (mem_result),
    .wb_reg_write  (wb_reg_write),
    .wb_dst        (wb_dst),
    .wb_data       (wb_data),
    .value         (w_rs_val)
  );

  operand_bypass #(.XLEN(XLEN), .RADDR_W(RADDR_W)) u_rt_bypass (
    .addr          (rf_rt_addr),
    .rf_data       (rf_rt_data),
    .mem_reg_write (mem_reg_write),
    .mem_mem_read  (mem_mem_read),
    .mem_dst       (mem_dst),
    .mem_result    (mem_result),
    .wb_reg_write  (wb_reg_write),
    .wb_dst        (wb_dst),
    .wb_data       (wb_data),
    .value         (w_rt_val)
  );

  // A load needs two stall cycles: once in EX, once more while in MEM.
  assign w_rs_used = uses_rs(w_op) && (rf_rs_addr != '0);
  assign w_rt_used = uses_rt(w_op) && (rf_rt_addr != '0);
  assign w_rs_hz   = w_rs_used &&
                     ((ex_reg_write && (ex_dst == rf_rs_addr)) ||
                      (mem_reg_write && mem_mem_read && (mem_dst == rf_rs_addr)));
  assign w_rt_hz   = w_rt_used &&
                     ((ex_reg_write && (ex_dst == rf_rt_addr)) ||
                      (mem_reg_write && mem_mem_read && (mem_dst == rf_rt_addr)));
  assign w_stall   = if_valid && !flush && (w_rs_hz || w_rt_hz);
  assign stall_out = w_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_id_valid     <= 1'b0;
      r_id_pc        <= '0;
      r_id_instr     <= '0;
      r_id_rs_val    <= '0;
      r_id_rt_val    <= '0;
      r_id_imm       <= '0;
      r_stall_cycles <= '0;
    end else begin
      if (flush || w_stall) begin
        r_id_valid <= 1'b0;
      end else begin
        r_id_valid  <= if_valid;
        r_id_pc     <= if_pc;
        r_id_instr  <= if_instr;
        r_id_rs_val <= w_rs_val;
        r_id_rt_val <= w_rt_val;
        r_id_imm    <= {{(XLEN-16){if_instr[IMM_MSB]}}, if_instr[IMM_MSB:0]};
      end
      if (w_stall && (r_stall_cycles != 32'hFFFF_FFFF))
        r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign id_valid     = r_id_valid;
  assign id_pc        = r_id_pc;
  assign id_instr     = r_id_instr;
  assign id_rs_val    = r_id_rs_val;
  assign id_rt_val    = r_id_rt_val;
  assign id_imm       = r_id_imm;
  assign stall_cycles = r_stall_cycles;

endmodule

`default_nettype wire
